alu_exec_seq: RTL

- Execute-stage sequencer that sits directly upstream of the ALU and feeds it.
- Accepts register-form instructions over a valid/ready handshake and reads two source registers from an internal register file.
- Drives registered opcode and operands into the combinational ALU, captures the ALU result, and writes it back to the destination register.
- Detects illegal opcodes and divide/modulo by zero; reports these as an error pulse instead of a writeback.

---
 rtl/alu_exec_seq_pkg.sv | 42 ++++
 rtl/alu_exec_seq_regfile.sv | 58 +++++
 rtl/alu_exec_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_exec_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_seq_pkg
// Shared definitions for the execute-stage sequencer:
//   - default datapath / register-file geometry
//   - ALU opcode encodings (0..12) and the highest legal opcode
//   - FSM state encoding
//   - helper that identifies the opcodes that trap on a zero divisor
// ---------------------------------------------------------------------------
package alu_exec_seq_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_NUM_REGS   = 8;
   localparam int DEF_REG_ADDR_W = 3;

   localparam logic [3:0] ALU_OP_ADDU = 4'd0;
   localparam logic [3:0] ALU_OP_SUBU = 4'd1;
   localparam logic [3:0] ALU_OP_MULU = 4'd2;
   localparam logic [3:0] ALU_OP_DIVU = 4'd3;
   localparam logic [3:0] ALU_OP_MOD  = 4'd4;
   localparam logic [3:0] ALU_OP_NOT  = 4'd5;
   localparam logic [3:0] ALU_OP_AND  = 4'd6;
   localparam logic [3:0] ALU_OP_OR   = 4'd7;
   localparam logic [3:0] ALU_OP_XOR  = 4'd8;
   localparam logic [3:0] ALU_OP_ADD  = 4'd9;
   localparam logic [3:0] ALU_OP_SUB  = 4'd10;
   localparam logic [3:0] ALU_OP_MUL  = 4'd11;
   localparam logic [3:0] ALU_OP_DIV  = 4'd12;
   localparam logic [3:0] ALU_OP_LAST = ALU_OP_DIV;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_e;

   // Opcodes whose second operand is a divisor.
   function automatic logic is_div_class(input logic [3:0] op);
      return (op == ALU_OP_DIVU) || (op == ALU_OP_MOD) || (op == ALU_OP_DIV);
   endfunction

endpackage

// File: rtl/alu_exec_seq_regfile.sv
// ---------------------------------------------------------------------------
// exec_regfile
// Register file for the execute sequencer.
//   clk, rst_n        : clock, asynchronous active-low reset (clears all regs)
//   rd_en             : when high, both read ports sample on the rising edge
//   raddr1/raddr2     : read addresses
//   rdata1/rdata2     : registered read data (held while rd_en is low)
//   we/waddr/wdata    : single write port, committed on the rising edge
//   dbg_addr/dbg_data : combinational debug read port
// ---------------------------------------------------------------------------
module exec_regfile
   import alu_exec_seq_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0]     rdata1,
   output logic [DATA_W-1:0]     rdata2,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0]     dbg_data
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Read ports are sampled rather than combinational: they are the ALU
   // operand registers, so the ALU inputs stay stable until the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata1 <= '0;
         rdata2 <= '0;
      end else if (rd_en) begin
         rdata1 <= regs[raddr1];
         rdata2 <= regs[raddr2];
      end
   end

   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// ---------------------------------------------------------------------------
// alu_exec_seq
// Execute-stage sequencer feeding a combinational ALU.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready             : instruction handshake
//   in_op/in_rd/in_rs1/in_rs2     : register-form instruction fields
//   alu_op/alu_operand1/2         : registered ALU inputs (stable EXEC..WB)
//   alu_out                       : combinational ALU result
//   wb_valid/wb_rd/wb_data        : one-cycle writeback report
//   err                           : one-cycle abort (illegal op, divide by 0)
//   dbg_addr/dbg_data             : combinational register-file peek
// Flow: IDLE -> READ -> EXEC -> WB, with a new instruction accepted in WB
// giving one instruction every three cycles.
// ---------------------------------------------------------------------------
module alu_exec_seq
   import alu_exec_seq_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_op,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [REG_ADDR_W-1:0] in_rs1,
   input  logic [REG_ADDR_W-1:0] in_rs2,
   output logic [3:0]            alu_op,
   output logic [DATA_W-1:0]     alu_operand1,
   output logic [DATA_W-1:0]     alu_operand2,
   input  logic [DATA_W-1:0]     alu_out,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  err,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0]     dbg_data
);

   state_e                  state_reg, state_next;
   logic [3:0]              op_reg;
   logic [REG_ADDR_W-1:0]   rd_reg, rs1_reg, rs2_reg;
   logic [3:0]              alu_op_reg;
   logic                    wb_valid_reg, err_reg;
   logic [REG_ADDR_W-1:0]   wb_rd_reg;
   logic [DATA_W-1:0]       wb_data_reg;
   logic                    handshake;
   logic                    illegal_exec;
   logic                    rf_rd_en, rf_we;

   assign in_ready  = (state_reg == ST_IDLE) || (state_reg == ST_WB);
   assign handshake = in_valid && in_ready;

   // Evaluated during EXEC, where the operands sampled in READ are already
   // registered; this gives the same verdict as checking regs[rs2] in READ.
   assign illegal_exec = (alu_op_reg > ALU_OP_LAST) ||
                         (is_div_class(alu_op_reg) && (alu_operand2 == '0));

   assign rf_rd_en = (state_reg == ST_READ);
   // The write lands on the edge leaving WB, i.e. before the next READ samples.
   assign rf_we    = (state_reg == ST_WB) && wb_valid_reg;

   exec_regfile #(
      .DATA_W     (DATA_W),
      .NUM_REGS   (NUM_REGS),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rf_rd_en),
      .raddr1   (rs1_reg),
      .raddr2   (rs2_reg),
      .rdata1   (alu_operand1),
      .rdata2   (alu_operand2),
      .we       (rf_we),
      .waddr    (wb_rd_reg),
      .wdata    (wb_data_reg),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (handshake) state_next = ST_READ;
         ST_READ: state_next = ST_EXEC;
         ST_EXEC: state_next = ST_WB;
         ST_WB:   state_next = handshake ? ST_READ : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         op_reg       <= '0;
         rd_reg       <= '0;
         rs1_reg      <= '0;
         rs2_reg      <= '0;
         alu_op_reg   <= '0;
         wb_valid_reg <= 1'b0;
         err_reg      <= 1'b0;
         wb_rd_reg    <= '0;
         wb_data_reg  <= '0;
      end else begin
         state_reg <= state_next;

         if (handshake) begin
            op_reg  <= in_op;
            rd_reg  <= in_rd;
            rs1_reg <= in_rs1;
            rs2_reg <= in_rs2;
         end

         if (state_reg == ST_READ) begin
            alu_op_reg <= op_reg;
         end

         // Result capture doubles as the WB report; pulses clear after WB.
         if (state_reg == ST_EXEC) begin
            wb_valid_reg <= !illegal_exec;
            err_reg      <= illegal_exec;
            wb_rd_reg    <= rd_reg;
            wb_data_reg  <= illegal_exec ? '0 : alu_out;
         end else begin
            wb_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
         end
      end
   end

   assign alu_op   = alu_op_reg;
   assign wb_valid = wb_valid_reg;
   assign err      = err_reg;
   assign wb_rd    = wb_rd_reg;
   assign wb_data  = wb_data_reg;

endmodule
